sar_result_fifo: RTL

// - Downstream of the SAR controller: captures each conversion word on its EOC cycle and checks dtop/dbot complementarity.
// - Optionally sums 2^OSR_LOG2 consecutive conversions and buffers the results in a small FIFO.
// - Presents the FIFO to the digital back-end over a valid/ready stream.

---
 rtl/sar_pkg.sv | 10 +
 rtl/sar_sync_fifo.sv | 56 +++++
 rtl/sar_result_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared SAR definitions. The SAR controller and its downstream blocks both use them.
package sar_pkg;

    typedef enum logic [1:0] {
        SAR_BUSY     = 2'd0,
        SAR_EOC      = 2'd1,
        SAR_SAMPLING = 2'd2
    } sar_state_t;

endpackage

// File: rtl/sar_sync_fifo.sv
// Synchronous FIFO. A push and a pop in the same cycle are both accepted, even when the FIFO is full.
module sar_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            // NOTE: storage is reset on purpose so the head reads 0 after reset; this costs a reset mux per bit.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sar_result_fifo.sv
// Captures SAR conversion words and checks that dtop and dbot are complements.
// Optionally sums 2^OSR_LOG2 words, then buffers the results for a valid/ready consumer.
module sar_result_fifo
    import sar_pkg::*;
#(
    parameter int N_BITS   = 12,
    parameter int OSR_LOG2 = 0,
    parameter int DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [1:0]                  sar_state,
    input  logic [N_BITS-1:0]           dtop,
    input  logic [N_BITS-1:0]           dbot,
    output logic [N_BITS+OSR_LOG2-1:0]  out_data,
    output logic                        out_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int W  = N_BITS + OSR_LOG2;
    localparam int CW = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;

    logic          capture;
    logic          per_err;
    logic          last;
    logic [W-1:0]  sample;
    logic [W-1:0]  sum;
    logic          err_sum;
    logic [W-1:0]  acc;
    logic          err_acc;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [W:0]    head;

    // State encoding 3 is not EOC, so it never captures.
    assign capture = en && (sar_state == SAR_EOC);
    assign per_err = (dbot != ~dtop);
    assign sample  = W'(dtop);
    assign sum     = acc + sample;
    assign err_sum = err_acc | per_err;
    assign last    = (count == CW'((1 << OSR_LOG2) - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            acc     <= '0;
            err_acc <= 1'b0;
            count   <= '0;
        end else if (capture) begin
            if (last) begin
                acc     <= '0;
                err_acc <= 1'b0;
                count   <= '0;
            end else begin
                acc     <= sum;
                err_acc <= err_sum;
                count   <= count + CW'(1);
            end
        end
    end

    assign push = capture && last;
    assign pop  = out_valid && out_ready;

    sar_sync_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({err_sum, sum}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign out_valid = !empty;
    assign out_data  = head[W-1:0];
    assign out_err   = head[W];

    // A drop sets ovf. If ovf_clr arrives in the same cycle, the set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (push && full && !pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
